// File: rtl/wb_pkg.sv
// Shared types and constants for the dual-lane writeback stage.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN_DEF   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } lq_entry_t;

    // x0 is hardwired, so a source aimed at it is consumed but never written.
    function automatic logic writes_reg(input logic valid, input logic [REG_ADDR_W-1:0] rd);
        return valid && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-response circular buffer: one push, up to two in-order pops, peek of head and head+1.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [XLEN-1:0]       push_data,
    input  logic [1:0]            pop_cnt,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic [REG_ADDR_W-1:0] next_rd,
    output logic [XLEN-1:0]       next_data,
    output logic [CntW-1:0]       count
);

    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]       data_mem [DEPTH];
    logic [PtrW-1:0]       rd_ptr;
    logic [PtrW-1:0]       wr_ptr;
    logic [PtrW-1:0]       next_ptr;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign next_ptr  = rd_ptr + PtrW'(1);
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign next_rd   = rd_mem[next_ptr];
    assign next_data = data_mem[next_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PtrW'(pop_cnt);
            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            count <= count + CntW'(push) - CntW'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Dual-lane writeback: ALU lanes first, buffered loads fill idle ports, collisions resolved.
// Optional WB_STATS_EN adds saturating full-cycle and collision-drop counters.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 4,
    parameter int unsigned XLEN     = XLEN_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        alu_valid_a,
    input  logic [REG_ADDR_W-1:0]       alu_rd_a,
    input  logic [XLEN-1:0]             alu_data_a,
    input  logic                        alu_valid_b,
    input  logic [REG_ADDR_W-1:0]       alu_rd_b,
    input  logic [XLEN-1:0]             alu_data_b,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [REG_ADDR_W-1:0]       ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    output logic [REG_ADDR_W-1:0]       rd_a,
    output logic [XLEN-1:0]             rd_data_a,
    output logic                        we_a,
    output logic [REG_ADDR_W-1:0]       rd_b,
    output logic [XLEN-1:0]             rd_data_b,
    output logic                        we_b,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        lq_empty
`ifdef WB_STATS_EN
    ,
    output logic [31:0]                 stat_lq_full_cycles,
    output logic [31:0]                 stat_collision_drops
`endif
);

    localparam int unsigned CntW = $clog2(LQ_DEPTH) + 1;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } port_sel_t;

    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic [REG_ADDR_W-1:0] next_rd;
    logic [XLEN-1:0]       next_data;
    logic                  push;
    logic [1:0]            pops;
    port_sel_t             sel_a;
    port_sel_t             sel_b;
    logic                  wr_a;
    logic                  wr_b;
    logic                  collide;

    // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign ld_ready = (lq_count < CntW'(LQ_DEPTH));
    assign lq_empty = (lq_count == '0);
    assign push     = ld_valid && ld_ready;

    wb_load_fifo #(
        .DEPTH (LQ_DEPTH),
        .XLEN  (XLEN)
    ) u_load_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop_cnt   (pops),
        .head_rd   (head_rd),
        .head_data (head_data),
        .next_rd   (next_rd),
        .next_data (next_data),
        .count     (lq_count)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        pops  = 2'd0;

        if (alu_valid_a) begin
            sel_a = '{valid: 1'b1, rd: alu_rd_a, data: alu_data_a};
        end else if (lq_count != '0) begin
            sel_a = '{valid: 1'b1, rd: head_rd, data: head_data};
            pops  = 2'd1;
        end

        // Port B takes the oldest entry port A left behind, keeping pops in FIFO order.
        if (alu_valid_b) begin
            sel_b = '{valid: 1'b1, rd: alu_rd_b, data: alu_data_b};
        end else if (pops == 2'd1) begin
            if (lq_count >= CntW'(2)) begin
                sel_b = '{valid: 1'b1, rd: next_rd, data: next_data};
                pops  = 2'd2;
            end
        end else if (lq_count != '0) begin
            sel_b = '{valid: 1'b1, rd: head_rd, data: head_data};
            pops  = 2'd1;
        end
    end

    assign wr_a    = writes_reg(sel_a.valid, sel_a.rd);
    assign wr_b    = writes_reg(sel_b.valid, sel_b.rd);
    assign collide = wr_a && wr_b && (sel_a.rd == sel_b.rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a      <= '0;
            rd_data_a <= '0;
            we_a      <= 1'b0;
            rd_b      <= '0;
            rd_data_b <= '0;
            we_b      <= 1'b0;
        end else begin
            rd_a      <= sel_a.rd;
            rd_data_a <= sel_a.data;
            we_a      <= wr_a && !collide;
            rd_b      <= sel_b.rd;
            rd_data_b <= sel_b.data;
            we_b      <= wr_b;
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lq_full_cycles  <= '0;
            stat_collision_drops <= '0;
        end else begin
            if (ld_valid && !ld_ready && (stat_lq_full_cycles != '1)) begin
                stat_lq_full_cycles <= stat_lq_full_cycles + 32'd1;
            end
            if (collide && (stat_collision_drops != '1)) begin
                stat_collision_drops <= stat_collision_drops + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue model predicts each cycle's register-file writes.
module tb_writeback_unit;

    localparam int unsigned LQ_DEPTH = 4;
    localparam int unsigned XLEN     = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              alu_valid_a = 1'b0;
    logic [4:0]        alu_rd_a = '0;
    logic [XLEN-1:0]   alu_data_a = '0;
    logic              alu_valid_b = 1'b0;
    logic [4:0]        alu_rd_b = '0;
    logic [XLEN-1:0]   alu_data_b = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [4:0]        ld_rd = '0;
    logic [XLEN-1:0]   ld_data = '0;
    logic [4:0]        rd_a;
    logic [XLEN-1:0]   rd_data_a;
    logic              we_a;
    logic [4:0]        rd_b;
    logic [XLEN-1:0]   rd_data_b;
    logic              we_b;
    logic [$clog2(LQ_DEPTH):0] lq_count;
    logic              lq_empty;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ld_t;

    typedef struct packed {
        logic            we_a;
        logic [4:0]      rd_a;
        logic [XLEN-1:0] d_a;
        logic            we_b;
        logic [4:0]      rd_b;
        logic [XLEN-1:0] d_b;
    } exp_t;

    ld_t  model_q[$];
    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    writeback_unit #(
        .LQ_DEPTH (LQ_DEPTH),
        .XLEN     (XLEN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid_a (alu_valid_a),
        .alu_rd_a    (alu_rd_a),
        .alu_data_a  (alu_data_a),
        .alu_valid_b (alu_valid_b),
        .alu_rd_b    (alu_rd_b),
        .alu_data_b  (alu_data_b),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .rd_a        (rd_a),
        .rd_data_a   (rd_data_a),
        .we_a        (we_a),
        .rd_b        (rd_b),
        .rd_data_b   (rd_data_b),
        .we_b        (we_b),
        .lq_count    (lq_count),
        .lq_empty    (lq_empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] actual,
                            input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock: check registered state, drive inputs, predict, clock, compare writes.
    task automatic cycle(input logic va, input logic [4:0] ra, input logic [XLEN-1:0] da,
                         input logic vb, input logic [4:0] rb, input logic [XLEN-1:0] db,
                         input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ldd,
                         output logic accepted);
        int   cnt;
        int   used;
        logic av, bv;
        ld_t  a, b;
        exp_t e, got;

        cnt = model_q.size();
        check_eq("lq_count", 64'(lq_count), 64'(cnt));
        check_eq("ld_ready", 64'(ld_ready), 64'(cnt < LQ_DEPTH));
        check_eq("lq_empty", 64'(lq_empty), 64'(cnt == 0));

        alu_valid_a = va; alu_rd_a = ra; alu_data_a = da;
        alu_valid_b = vb; alu_rd_b = rb; alu_data_b = db;
        ld_valid = lv;    ld_rd = lr;    ld_data = ldd;

        used = 0;
        av = 1'b0; bv = 1'b0; a = '0; b = '0;
        if (va) begin av = 1'b1; a = '{rd: ra, data: da}; end
        else if (cnt > 0) begin av = 1'b1; a = model_q[0]; used = 1; end
        if (vb) begin bv = 1'b1; b = '{rd: rb, data: db}; end
        else if (cnt > used) begin bv = 1'b1; b = model_q[used]; used++; end
        for (int i = 0; i < used; i++) void'(model_q.pop_front());
        accepted = lv && (cnt < LQ_DEPTH);
        if (accepted) model_q.push_back('{rd: lr, data: ldd});

        e.we_b = bv && (b.rd != 5'd0);
        e.we_a = av && (a.rd != 5'd0) && !(e.we_b && (b.rd == a.rd));
        e.rd_a = a.rd; e.d_a = a.data; e.rd_b = b.rd; e.d_b = b.data;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_eq("we_a", 64'(we_a), 64'(got.we_a));
        check_eq("we_b", 64'(we_b), 64'(got.we_b));
        if (got.we_a) begin
            check_eq("rd_a", 64'(rd_a), 64'(got.rd_a));
            check_eq("rd_data_a", 64'(rd_data_a), 64'(got.d_a));
        end
        if (got.we_b) begin
            check_eq("rd_b", 64'(rd_b), 64'(got.rd_b));
            check_eq("rd_data_b", 64'(rd_data_b), 64'(got.d_b));
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    initial begin
        logic acc;

        // Reset held low
        #12;
        check_eq("rst_we_a", 64'(we_a), 64'd0);
        check_eq("rst_we_b", 64'(we_b), 64'd0);
        check_eq("rst_ld_ready", 64'(ld_ready), 64'd1);
        check_eq("rst_lq_empty", 64'(lq_empty), 64'd1);
        check_eq("rst_lq_count", 64'(lq_count), 64'd0);
        check_eq("rst_rd_data_a", 64'(rd_data_a), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // ALU only, collision, x0 filter
        cycle(1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0, acc);
        check_eq("alu_rd_a", 64'(rd_a), 64'd5);
        check_eq("alu_rd_b", 64'(rd_b), 64'd6);
        cycle(1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 0, 0, 0, acc);
        check_eq("coll_we_a", 64'(we_a), 64'd0);
        check_eq("coll_data_b", 64'(rd_data_b), 64'hBBBB);
        cycle(1, 0, 32'h33, 1, 3, 32'h44, 0, 0, 0, acc);
        check_eq("x0_we_a", 64'(we_a), 64'd0);

        // Loads buffered behind busy lanes, then drained
        cycle(1, 1, 32'h101, 1, 2, 32'h102, 1, 8, 32'h808, acc);
        cycle(1, 1, 32'h111, 1, 2, 32'h112, 1, 9, 32'h909, acc);
        cycle(1, 1, 32'h121, 1, 2, 32'h122, 1, 10, 32'hA0A, acc);
        check_eq("lq3_count", 64'(lq_count), 64'd3);
        cycle(1, 1, 32'h131, 0, 0, 0, 0, 0, 0, acc);
        check_eq("drain_rd_b", 64'(rd_b), 64'd8);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
        check_eq("pair_rd_a", 64'(rd_a), 64'd9);
        check_eq("pair_rd_b", 64'(rd_b), 64'd10);
        check_eq("pair_empty", 64'(lq_empty), 64'd1);

        // Backpressure: fill, then hold a fifth load until a slot frees
        for (int i = 0; i < 4; i++)
            cycle(1, 1, 32'h200 + i, 1, 2, 32'h300 + i, 1, 5'(11 + i), 32'hC00 + i, acc);
        check_eq("full_ready", 64'(ld_ready), 64'd0);
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (i < 2) cycle(1, 1, 32'h400, 1, 2, 32'h401, 1, 15, 32'hF0F, acc);
            else       cycle(0, 0, 0, 0, 0, 0, 1, 15, 32'hF0F, acc);
        end
        check_eq("ld5_accepted", 64'(acc), 64'd1);
        idle(4);

        // Random mix of lane traffic and loads
        for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom, acc);
        end
        idle(4);

        // Reset with two loads buffered
        cycle(1, 1, 32'h501, 1, 2, 32'h502, 1, 20, 32'h1414, acc);
        cycle(1, 1, 32'h511, 1, 2, 32'h512, 1, 21, 32'h1515, acc);
        check_eq("pre_rst_count", 64'(lq_count), 64'd2);
        #2 reset_n = 1'b0;
        alu_valid_a = 1'b0; alu_valid_b = 1'b0; ld_valid = 1'b0;
        #1;
        check_eq("mid_rst_count", 64'(lq_count), 64'd0);
        check_eq("mid_rst_we_a", 64'(we_a), 64'd0);
        model_q.delete();
        exp_q.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
